// File: rtl/tile_line_fetcher_pkg.sv
// Shared tile geometry, default memory map and fetch-state encoding for the
// scanline tile fetcher.
package tile_line_fetcher_pkg;

  localparam int TileSize        = 8;
  localparam int BytesPerTileRow = 4;
  localparam int BytesPerTile    = 32;
  localparam int PixelsPerByte   = 2;
  localparam int RowBits         = BytesPerTileRow * 8;
  localparam int PixPerRow       = BytesPerTileRow * PixelsPerByte;

  localparam int DefMapBase      = 0;
  localparam int DefPatternBase  = 8192;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_NAME,
    FS_PAT0,
    FS_PAT1,
    FS_PAT2,
    FS_PAT3,
    FS_HOLD
  } fetch_state_e;

endpackage

// File: rtl/tile_line_fetcher_shifter.sv
// One tile row of 4bpp pixels, shifted out leftmost nibble first over a
// valid/ready handshake.
module tile_row_shifter
  import tile_line_fetcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [RowBits-1:0] load_data_i,
  input  logic               load_last_i,
  input  logic               ready_i,
  output logic [3:0]         pixel_o,
  output logic               valid_o,
  output logic               last_o,
  output logic               can_load_o
);

  logic [RowBits-1:0] sbuf_q, sbuf_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               last_q, last_d;
  logic               hs, drain;

  assign hs         = full_q & ready_i;
  assign drain      = hs & (cnt_q == 3'(PixPerRow - 1));
  // Refill is allowed in the same edge the final pixel leaves, so rows abut.
  assign can_load_o = ~full_q | drain;
  assign pixel_o    = sbuf_q[RowBits-1 -: 4];
  assign valid_o    = full_q;
  assign last_o     = full_q & last_q & (cnt_q == 3'(PixPerRow - 1));

  always_comb begin
    sbuf_d = sbuf_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    last_d = last_q;
    if (clear_i) begin
      full_d = 1'b0;
      last_d = 1'b0;
    end else if (load_i) begin
      sbuf_d = load_data_i;
      cnt_d  = 3'd0;
      full_d = 1'b1;
      last_d = load_last_i;
    end else if (hs) begin
      sbuf_d = sbuf_q << 4;
      cnt_d  = cnt_q + 3'd1;
      if (drain) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sbuf_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      sbuf_q <= sbuf_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tile_line_fetcher.sv
// Scanline renderer: walks the name table, fetches each tile row into a
// fetch buffer and hands it to the row shifter while the next tile is read.
module tile_line_fetcher
  import tile_line_fetcher_pkg::*;
#(
  parameter int Bits         = 16,
  parameter int MapBase      = DefMapBase,
  parameter int PatternBase  = DefPatternBase,
  parameter int TilesPerLine = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lineStart,
  input  logic [7:0]      line,
  output logic            busy,
  output logic [Bits-1:0] ramAddress,
  input  logic [7:0]      ramData,
  output logic [3:0]      pixel,
  output logic            pixelValid,
  input  logic            pixelReady,
  output logic            pixelLast
);

  localparam int ColW = (TilesPerLine > 1) ? $clog2(TilesPerLine) : 1;

  fetch_state_e       fsm_q, fsm_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [7:0]         ln_q, ln_d;
  logic [7:0]         tile_q, tile_d;
  logic [RowBits-1:0] fbuf_q, fbuf_d;
  logic               fbuf_full_q, fbuf_full_d;
  logic               fbuf_last_q, fbuf_last_d;
  logic [Bits-1:0]    addr_q;

  logic               last_col, fb_avail, fb_last, sh_can_load, sh_load;
  logic [RowBits-1:0] fb_data;
  logic [1:0]         pat_k;
  logic [31:0]        name_addr, pat_addr;

  assign last_col = (32'(col_q) == 32'(TilesPerLine - 1));

  // In PAT3 the row can go straight to the shifter with the byte still on ramData.
  assign fb_avail = fbuf_full_q | (fsm_q == FS_PAT3);
  assign fb_data  = fbuf_full_q ? fbuf_q : {fbuf_q[RowBits-1:8], ramData};
  assign fb_last  = fbuf_full_q ? fbuf_last_q : last_col;
  assign sh_load  = fb_avail & sh_can_load & ~lineStart;

  always_comb begin
    pat_k = 2'd0;
    case (fsm_q)
      FS_PAT1: pat_k = 2'd1;
      FS_PAT2: pat_k = 2'd2;
      FS_PAT3: pat_k = 2'd3;
      default: ;
    endcase
  end

  assign name_addr = 32'(MapBase) + (32'(ln_q) / 32'(TileSize)) * 32'(TilesPerLine)
                   + 32'(col_q);
  assign pat_addr  = 32'(PatternBase) + 32'(tile_q) * 32'(BytesPerTile)
                   + (32'(ln_q) % 32'(TileSize)) * 32'(BytesPerTileRow) + 32'(pat_k);

  always_comb begin
    case (fsm_q)
      FS_NAME:                             ramAddress = name_addr[Bits-1:0];
      FS_PAT0, FS_PAT1, FS_PAT2, FS_PAT3:  ramAddress = pat_addr[Bits-1:0];
      default:                             ramAddress = addr_q;
    endcase
  end

  always_comb begin
    fsm_d       = fsm_q;
    col_d       = col_q;
    ln_d        = ln_q;
    tile_d      = tile_q;
    fbuf_d      = fbuf_q;
    fbuf_full_d = fbuf_full_q;
    fbuf_last_d = fbuf_last_q;
    if (lineStart) begin
      fsm_d       = FS_NAME;
      col_d       = '0;
      ln_d        = line;
      fbuf_full_d = 1'b0;
    end else begin
      if (sh_load) fbuf_full_d = 1'b0;
      case (fsm_q)
        FS_NAME: begin
          tile_d = ramData;
          fsm_d  = FS_PAT0;
        end
        FS_PAT0: begin fbuf_d[31:24] = ramData; fsm_d = FS_PAT1; end
        FS_PAT1: begin fbuf_d[23:16] = ramData; fsm_d = FS_PAT2; end
        FS_PAT2: begin fbuf_d[15:8]  = ramData; fsm_d = FS_PAT3; end
        FS_PAT3: begin
          fbuf_d[7:0] = ramData;
          fbuf_last_d = last_col;
          if (!sh_load) fbuf_full_d = 1'b1;
          if (last_col) fsm_d = FS_IDLE;
          else begin
            col_d = col_q + 1'b1;
            fsm_d = sh_load ? FS_NAME : FS_HOLD;
          end
        end
        FS_HOLD: if (sh_load) fsm_d = FS_NAME;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q       <= FS_IDLE;
      col_q       <= '0;
      ln_q        <= '0;
      tile_q      <= '0;
      fbuf_q      <= '0;
      fbuf_full_q <= 1'b0;
      fbuf_last_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      fsm_q       <= fsm_d;
      col_q       <= col_d;
      ln_q        <= ln_d;
      tile_q      <= tile_d;
      fbuf_q      <= fbuf_d;
      fbuf_full_q <= fbuf_full_d;
      fbuf_last_q <= fbuf_last_d;
      addr_q      <= ramAddress;
    end
  end

  tile_row_shifter u_shifter (
    .clk         (clk),
    .rst_ni      (reset),
    .clear_i     (lineStart),
    .load_i      (sh_load),
    .load_data_i (fb_data),
    .load_last_i (fb_last),
    .ready_i     (pixelReady),
    .pixel_o     (pixel),
    .valid_o     (pixelValid),
    .last_o      (pixelLast),
    .can_load_o  (sh_can_load)
  );

  assign busy = (fsm_q != FS_IDLE) | fbuf_full_q | pixelValid;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher: RAM image model, hand-computed pixel
// heads, latency, stall stability, abort and reset behaviour.
module tb_tile_line_fetcher;
  import tile_line_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lineStart = 1'b0;
  logic [7:0]  line = 8'd0;
  logic        busy;
  logic [15:0] ramAddress;
  logic [7:0]  ramData;
  logic [3:0]  pixel;
  logic        pixelValid;
  logic        pixelReady = 1'b0;
  logic        pixelLast;

  logic [7:0]  mem [0:65535];
  logic [3:0]  cap [0:23];
  logic [31:0] a1, a2;
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign ramData = mem[ramAddress];

  tile_line_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .lineStart  (lineStart),
    .line       (line),
    .busy       (busy),
    .ramAddress (ramAddress),
    .ramData    (ramData),
    .pixel      (pixel),
    .pixelValid (pixelValid),
    .pixelReady (pixelReady),
    .pixelLast  (pixelLast)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_pix(input int ln, input int p);
    logic [7:0] t, b;
    t = mem[(ln / 8) * 32 + p / 8];
    b = mem[8192 + int'(t) * 32 + (ln % 8) * 4 + (p % 8) / 2];
    return (p % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic start_line(input int L);
    lineStart = 1'b1;
    line      = 8'(L);
    tick();
    lineStart = 1'b0;
  endtask

  // Entered in cycle 1 of a line; consumes the whole line unless abort_at >= 0.
  task automatic run_stream(input int L, input bit rnd, input int abort_at, input int abort_line);
    int idx = 0, c = 1, first_c = -1, first_hs = -1, last_hs = -1, nlast = 0, bad_last = 0;
    bit stall = 1'b0, saw_hold = 1'b0;
    logic [3:0] ppix = 4'd0;
    logic plast = 1'b0;
    while (idx < 256 && c < 4000) begin
      if (c == 1) a1 = 32'(ramAddress);
      if (c == 2) a2 = 32'(ramAddress);
      if (pixelValid && first_c < 0) first_c = c;
      if (dut.fsm_q == FS_HOLD) saw_hold = 1'b1;
      if (stall) begin
        chk("stall_pix", 32'(pixel), 32'(ppix));
        chk("stall_vld", 32'(pixelValid), 32'd1);
        chk("stall_last", 32'(pixelLast), 32'(plast));
      end
      if (abort_at >= 0 && idx == abort_at) begin
        pixelReady = 1'b0;
        lineStart  = 1'b1;
        line       = 8'(abort_line);
        tick();
        lineStart  = 1'b0;
        return;
      end
      pixelReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pixelValid && pixelReady) begin
        chk("pix", 32'(pixel), 32'(exp_pix(L, idx)));
        if (idx < 24) cap[idx] = pixel;
        if (pixelLast) begin
          nlast++;
          if (idx != 255) bad_last++;
        end
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        idx++;
      end
      stall = pixelValid && !pixelReady;
      ppix  = pixel;
      plast = pixelLast;
      tick();
      c++;
    end
    pixelReady = 1'b0;
    chk("first_valid_cycle", 32'(first_c), 32'd6);
    chk("pix_count", 32'(idx), 32'd256);
    chk("last_count", 32'(nlast), 32'd1);
    chk("last_misplaced", 32'(bad_last), 32'd0);
    chk("valid_after_last", 32'(pixelValid), 32'd0);
    chk("busy_after_last", 32'(busy), 32'd0);
    if (!rnd) chk("no_bubbles", 32'(last_hs - first_hs), 32'd255);
    else      chk("saw_hold", 32'(saw_hold), 32'd1);
  endtask

  initial begin
    logic [3:0] r0 [0:7];
    logic [3:0] r1 [0:7];
    logic [3:0] v;
    r0 = '{4'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd8, 4'd8, 4'd0};
    r1 = '{4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[1] = 8'd1; mem[2] = 8'd2; mem[32] = 8'd3;
    mem[8192] = 8'h08; mem[8193] = 8'h80; mem[8194] = 8'h08; mem[8195] = 8'h80;
    mem[8196] = 8'h77; mem[8197] = 8'h88; mem[8198] = 8'h88; mem[8199] = 8'h88;
    for (int n = 1; n < 16; n++) begin
      v = 4'(n - 1);
      for (int j = 0; j < 32; j++) mem[8192 + 32 * n + j] = {v, v};
    end

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(pixelValid), 32'd0);
    chk("rst_last", 32'(pixelLast), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_addr", 32'(ramAddress), 32'd0);
    reset = 1'b1;
    tick();

    // Case 1: line 0, always ready
    start_line(0);
    chk("c1_busy", 32'(busy), 32'd1);
    run_stream(0, 1'b0, -1, 0);
    for (int i = 0; i < 24; i++)
      chk("c1_head", 32'(cap[i]), 32'(i < 8 ? r0[i] : (i < 16 ? 4'd0 : 4'd1)));

    // Case 2: line 1
    start_line(1);
    run_stream(1, 1'b0, -1, 0);
    chk("c2_pat0_addr", a2, 32'd8196);
    for (int i = 0; i < 8; i++) chk("c2_head", 32'(cap[i]), 32'(r1[i]));

    // Case 3: line 8 uses name table row 1
    start_line(8);
    run_stream(8, 1'b0, -1, 0);
    chk("c3_name_addr", a1, 32'd32);
    for (int i = 0; i < 8; i++) chk("c3_head", 32'(cap[i]), 32'd2);

    // Case 4: random backpressure
    start_line(0);
    run_stream(0, 1'b1, -1, 0);

    // Case 5: abort at pixel 100, restart with line 1
    start_line(0);
    run_stream(0, 1'b0, 100, 1);
    chk("c5_valid_after_abort", 32'(pixelValid), 32'd0);
    chk("c5_busy_after_abort", 32'(busy), 32'd1);
    run_stream(1, 1'b0, -1, 0);
    for (int i = 0; i < 8; i++) chk("c5_head", 32'(cap[i]), 32'(r1[i]));

    // Case 6: reset mid-line, lineStart during reset ignored
    start_line(0);
    pixelReady = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("c6_midline_valid", 32'(pixelValid), 32'd1);
    reset     = 1'b0;
    lineStart = 1'b1;
    line      = 8'd1;
    tick();
    chk("c6_busy", 32'(busy), 32'd0);
    chk("c6_valid", 32'(pixelValid), 32'd0);
    chk("c6_last", 32'(pixelLast), 32'd0);
    chk("c6_pixel", 32'(pixel), 32'd0);
    chk("c6_addr", 32'(ramAddress), 32'd0);
    reset     = 1'b1;
    lineStart = 1'b0;
    tick(); tick();
    chk("c6_idle_busy", 32'(busy), 32'd0);
    chk("c6_idle_valid", 32'(pixelValid), 32'd0);
    chk("c6_idle_addr", 32'(ramAddress), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_line_fetcher.md
Name: tile_line_fetcher

Overview:
- Read-side client of the shared byte-wide video/system RAM.
- Renders one 256-pixel scanline per request from an 8x8 4bpp tile system:
  - a 32-wide name table holds one tile index byte per map cell;
  - pattern memory holds 32 bytes per tile: 4 bytes per tile row, 2 pixels per byte, high nibble leftmost.
- Streams 4-bit palette indices to the video output stage over a valid/ready handshake.
- Double-buffers one tile row, so fetching overlaps pixel output.

Parameters:
Bits, 16, RAM address width.
MapBase, 0, byte address of name table entry (row 0, col 0).
PatternBase, 8192, byte address of tile 0 pattern row 0.
TilesPerLine, 32, tiles per scanline and name table row stride.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  synchronous, active-low reset.
lineStart  in  1  one-cycle request to render scanline `line`.
line  in  8  scanline number, sampled when lineStart=1.
busy  out  1  high from the accepted request until the last pixel handshake.
ramAddress  out  Bits  RAM read address, combinational from fetch state and counters.
ramData  in  8  RAM read data, combinational from ramAddress (same-cycle read).
pixel  out  4  palette index.
pixelValid  out  1  pixel is valid.
pixelReady  in  1  downstream accepts pixel this cycle.
pixelLast  out  1  qualifies the final pixel (pixel 255) of the line.

Behaviour:
- Reset (reset=0 at an edge): busy=0, pixelValid=0, pixelLast=0, pixel=0, ramAddress=0; both buffers empty; fetch FSM=IDLE.
- Fetch FSM states: IDLE, NAME, PAT0, PAT1, PAT2, PAT3, HOLD.
- Addressing, with col = 0..TilesPerLine-1 and ln = latched line:
  - NAME: ramAddress = MapBase + ln[7:3]*TilesPerLine + col.
  - PATk: ramAddress = PatternBase + tile*32 + ln[2:0]*4 + k.
  - All sums are truncated to Bits.
- ramData capture, end of cycle:
  - NAME: latches tile.
  - PATk: latches byte k into the fetch buffer.
- Transitions:
  - IDLE->NAME on lineStart.
  - NAME->PAT0->PAT1->PAT2->PAT3.
  - PAT3 ->NAME (col+1) if the fetch buffer is free after this edge and more tiles remain.
  - PAT3 ->HOLD if the fetch buffer is still occupied.
  - PAT3 ->IDLE after the last tile is captured.
  - HOLD->NAME once the fetch buffer moves to the shift buffer.
  - In HOLD and IDLE, ramAddress holds its last value.
- Buffer transfer: the fetch buffer (32 bits) loads the shift buffer when the shift buffer is empty, or when its 8th pixel handshakes this cycle.
  - Loading in the same edge as the PAT3 capture is permitted (bypass).
- Shift buffer output:
  - pixelValid=1 while it holds pixels.
  - pixel = nibble order byte0[7:4], byte0[3:0], byte1[7:4] ... byte3[3:0].
  - It advances only on pixelValid & pixelReady.
  - pixel/pixelValid/pixelLast hold stable while pixelReady=0.
- Latency: with lineStart sampled at edge 0, NAME occupies cycle 1, PAT0-3 occupy cycles 2-5, and the first pixelValid=1 is in cycle 6.
- Throughput: with pixelReady held high, 256 pixels are output on 256 consecutive cycles with no bubbles (5-cycle fetch < 8-cycle drain).
- pixelLast=1 only with pixel 255. After its handshake: pixelValid=0 and busy=0 in the next cycle; FSM in IDLE.
- lineStart while busy aborts the current line. At that edge: both buffers are cleared, pixelValid=0, and a new line starts with the newly sampled line, with the same 6-cycle latency.
- lineStart with reset=0: reset wins.

Decomposition:
- Shared video package: tile geometry constants (TileSize=8, BytesPerTileRow=4, BytesPerTile=32, PixelsPerByte=2), default MapBase/PatternBase, and the fetch-state enumeration.
- One natural sub-module: tile_row_shifter. It holds the 32-bit shift buffer, the 3-bit pixel counter and the valid/ready output logic, with a load input and an empty/last-drain indication.

Test Plan:
RAM image for all cases:
- name table bytes: [0]=0, [1]=1, [2]=2, [32]=3;
- pattern tile 0 rows 0/1: 08 80 08 80 / 77 88 88 88;
- tile n>=1: all 32 bytes = {n-1,n-1}.

1. Reset then lineStart line=0, pixelReady=1 -> first pixelValid in cycle 6; pixels 0-7 = 0,8,8,0,0,8,8,0; pixels 8-15 = 0; pixels 16-23 = 1.
2. line=1 -> pixels 0-7 = 7,7,8,8,8,8,8,8; ramAddress in cycle 2 = 8196.
3. line=8 -> cycle-1 ramAddress = 32; pixels 0-7 = 2 (tile 3).
4. pixelReady toggled randomly -> pixel stream identical to case 1; outputs stable while stalled; fetch reaches HOLD; exactly one pixelLast on pixel 255; busy falls next cycle.
5. lineStart line=1 asserted mid-line at pixel 100 -> pixelValid low next cycle; restart with line 1 data after 6 cycles.
6. reset=0 asserted mid-line -> all outputs zero at the next edge; lineStart during reset is ignored.
